// File: rtl/adc_osr_decimator.sv
// Oversampling decimator: sums 4^k ADC results per window, emits one MSB-aligned word 1 cycle after the last sample.
// No backpressure: an unacked word is overwritten on the next completion and overrun_out latches.
module adc_osr_decimator #(
  parameter int DATA_BITS = 12,
  parameter int OUT_BITS  = 16,
  parameter int ACC_BITS  = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_in,
  input  logic [2:0]           osr_mode_in,
  input  logic [DATA_BITS-1:0] adc_data_in,
  input  logic                 adc_strobe_in,
  output logic [OUT_BITS-1:0]  dout,
  output logic                 dout_valid,
  input  logic                 dout_ack,
  output logic                 overrun_out,
  output logic [7:0]           window_cnt_out
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACCUM} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_strobe_d;
  logic [2:0]           r_mode;
  logic [ACC_BITS-1:0]  r_acc;
  logic [7:0]           r_cnt;
  logic [OUT_BITS-1:0]  r_dout;
  logic                 r_dout_valid;
  logic                 r_overrun;

  logic [2:0]           w_k;
  logic [7:0]           w_last;
  logic                 w_event;
  logic                 w_sample;
  logic                 w_complete;
  logic [ACC_BITS-1:0]  w_sum;
  logic [ACC_BITS-1:0]  w_word;

  // Window geometry comes from the latched mode; unknown modes behave as bypass.
  always_comb begin
    w_k    = 3'd0;
    w_last = 8'd0;
    case (r_mode)
      3'd1: begin w_k = 3'd1; w_last = 8'd3;   end
      3'd2: begin w_k = 3'd2; w_last = 8'd15;  end
      3'd3: begin w_k = 3'd3; w_last = 8'd63;  end
      3'd4: begin w_k = 3'd4; w_last = 8'd255; end
      default: begin w_k = 3'd0; w_last = 8'd0; end
    endcase
  end

  assign w_event    = adc_strobe_in & ~r_strobe_d;
  assign w_sample   = (r_state == S_ACCUM) & enable_in & w_event;
  assign w_complete = w_sample & (r_cnt == w_last);
  assign w_sum      = r_acc + {{(ACC_BITS-DATA_BITS){1'b0}}, adc_data_in};
  assign w_word     = (w_sum >> w_k) << (3'd4 - w_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable_in) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ARM;
        S_ARM:   w_state_nxt = S_ACCUM;
        S_ACCUM: w_state_nxt = S_ACCUM;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe_d   <= 1'b0;
      r_mode       <= 3'd0;
      r_acc        <= '0;
      r_cnt        <= 8'd0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_strobe_d <= adc_strobe_in;

      if (!enable_in || r_state == S_IDLE) begin
        r_acc <= '0;
        r_cnt <= 8'd0;
      end else if (r_state == S_ARM) begin
        r_mode <= osr_mode_in;
        r_acc  <= '0;
        r_cnt  <= 8'd0;
      end else if (w_complete) begin
        r_mode <= osr_mode_in;
        r_acc  <= '0;
        r_cnt  <= 8'd0;
      end else if (w_sample) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 8'd1;
      end

      // A completion coinciding with an ack replaces the word without flagging overrun.
      if (w_complete) begin
        r_dout       <= w_word[OUT_BITS-1:0];
        r_dout_valid <= 1'b1;
        if (r_dout_valid && !dout_ack) r_overrun <= 1'b1;
      end else if (dout_ack) begin
        r_dout_valid <= 1'b0;
      end

      if (!enable_in) r_overrun <= 1'b0;
    end
  end

  assign dout           = r_dout;
  assign dout_valid     = r_dout_valid;
  assign overrun_out    = r_overrun;
  assign window_cnt_out = r_cnt;

endmodule
